aes_key_sched: RTL and testbench
================================

AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, number of AES-128 rounds; round keys 0..NUM_ROUNDS emitted.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: flush  input  1  synchronous abort of the current schedule.
REQ-005 SHALL have port: key  input  [3:0][3:0][7:0]  cipher key; key[i] = word w[i], key[i][0] = MSB byte of the word.
REQ-006 SHALL have port: key_valid  input  1  key is offered.
REQ-007 SHALL have port: key_ready  output  1  block accepts key.
REQ-008 SHALL have port: rk  output  [3:0][3:0][7:0]  current round key, same layout as key.
REQ-009 SHALL have port: rk_idx  output  4  round index of rk, 0..NUM_ROUNDS.
REQ-010 SHALL have port: rk_valid  output  1  rk is presented.
REQ-011 SHALL have port: rk_ready  input  1  downstream round stage consumes rk.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and EMIT.
REQ-013 IDLE: key_ready=1, rk_valid=0; on key_valid&key_ready: rk<=key, rk_idx<=0, go to EMIT.
REQ-014 EMIT: key_ready=0, rk_valid=1; rk and rk_idx SHALL hold stable while rk_ready=0.
REQ-015 EMIT with rk_ready=1 and rk_idx<NUM_ROUNDS: rk<=next key, rk_idx<=rk_idx+1, stay in EMIT.
REQ-016 EMIT with rk_ready=1 and rk_idx==NUM_ROUNDS: go to IDLE; rk retains its last value.
REQ-017 Next key SHALL be: t = SubWord(RotWord(w[3])) ^ {RCON[rk_idx+1],00,00,00}; w'[0]=w[0]^t; w'[i]=w'[i-1]^w[i] for i=1..3.
REQ-018 RotWord({b0,b1,b2,b3}) SHALL be {b1,b2,b3,b0}; SubWord SHALL apply the AES S-box to each byte.
REQ-019 RCON[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-020 Latency: key accepted in cycle N gives rk_valid=1 with rk_idx=0 in cycle N+1; one round key per cycle thereafter under continuous rk_ready.
REQ-021 The next-key path SHALL be combinational from registered rk; rk and rk_idx SHALL be registered outputs.
REQ-022 flush=1 SHALL force IDLE at the next edge regardless of state or handshakes; flush SHALL win over a simultaneous key or rk handshake.
REQ-023 key_valid while in EMIT SHALL be ignored (key_ready=0); no key SHALL be lost or merged.
REQ-024 rk_idx SHALL never exceed NUM_ROUNDS; no wrap-around to 0 without a new key.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, rk=0, rk_idx=0, rk_valid=0, key_ready=1 after release.
REQ-026 Reset asserted mid-schedule SHALL discard the schedule; the first key after release SHALL restart at rk_idx=0.

Configuration
REQ-027 Macro AES_KEY_SCHED_LAST_EN: when defined, output port rk_last (1 bit) SHALL exist, equal to rk_valid & (rk_idx==NUM_ROUNDS).
REQ-028 Without AES_KEY_SCHED_LAST_EN, rk_last SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package aes_pkg SHALL hold typedef aes_block_t ([3:0][3:0][7:0]), typedef aes_word_t ([3:0][7:0]), constant AES_RCON table and AES128_ROUNDS=10.
REQ-030 The four SubWord S-box lookups SHALL each be an instance of combinational sub-module aes_sbox (8-bit in, 8-bit out).

Verification
REQ-031 FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1 -> rk_idx=1 rk=a0fafe17 88542cb1 23a33939 2a6c7605; rk_idx=10 rk=d014f9a8 c9ee2589 e13f0cc8 b6630ca6; 11 keys in 11 consecutive cycles.
REQ-032 Same key, rk_ready toggled 1/0 randomly -> identical 11-key sequence; rk stable on every rk_ready=0 cycle.
REQ-033 Second key_valid pulsed during EMIT -> key_ready=0, sequence unaffected; second key accepted only after rk_idx=10 handshake.
REQ-034 flush at rk_idx=4 together with rk_ready=1 -> next cycle IDLE, rk_valid=0, key_ready=1; new key restarts at rk_idx=0.
REQ-035 rst low at rk_idx=6 mid-cycle -> immediately rk_valid=0, rk=0, rk_idx=0; after release key 00..00 -> rk_idx=1 rk=62636363 62636363 62636363 62636363.
REQ-036 With AES_KEY_SCHED_LAST_EN -> rk_last=1 only on the rk_idx=10 valid cycle; without it, REQ-031 passes unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 shared types and constants for the key schedule.
// aes_block_t[i] is word w[i]; aes_block_t[i][0] is the MSB byte of that word.
package aes_pkg;

  typedef logic [3:0][7:0]      aes_word_t;
  typedef logic [3:0][3:0][7:0] aes_block_t;

  localparam int AES128_ROUNDS = 10;

  // Round constants indexed by round number; entry 0 and entries past 10 are unused.
  localparam logic [7:0] AES_RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ks_state_e;

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte substitution.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Row-major table: element 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key schedule: accepts a cipher key and streams round keys 0..NUM_ROUNDS
// over a valid/ready handshake, one per cycle while the consumer is ready.
// Optional feature macro AES_KEY_SCHED_LAST_EN adds the rk_last output.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  aes_block_t key,
  input  logic       key_valid,
  output logic       key_ready,
  output aes_block_t rk,
  output logic [3:0] rk_idx,
  output logic       rk_valid,
  input  logic       rk_ready
`ifdef AES_KEY_SCHED_LAST_EN
  ,
  output logic       rk_last
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  ks_state_e  state_reg;
  aes_block_t rk_reg;
  logic [3:0] rk_idx_reg;
  logic       rk_valid_reg;
  logic       key_ready_reg;

  aes_word_t  rot_word;
  aes_word_t  sub_word;
  aes_word_t  t_word;
  aes_word_t  w0_next, w1_next, w2_next, w3_next;
  aes_block_t rk_next;
  logic [3:0] rcon_idx;

  // RotWord of w[3] feeds four S-box lookups.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      assign rot_word[gi] = rk_reg[3][(gi + 1) % 4];
      aes_sbox u_sbox (
        .din  (rot_word[gi]),
        .dout (sub_word[gi])
      );
    end
  endgenerate

  assign rcon_idx = rk_idx_reg + 4'd1;

  // Next round key is derived combinationally from the registered current key.
  always_comb begin
    t_word    = sub_word;
    t_word[0] = sub_word[0] ^ AES_RCON[rcon_idx];
    w0_next   = rk_reg[0] ^ t_word;
    w1_next   = w0_next ^ rk_reg[1];
    w2_next   = w1_next ^ rk_reg[2];
    w3_next   = w2_next ^ rk_reg[3];
    rk_next   = {w3_next, w2_next, w1_next, w0_next};
  end

  // Handshake FSM; flush overrides any handshake, rk holds its last value on exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      rk_reg        <= '0;
      rk_idx_reg    <= '0;
      rk_valid_reg  <= 1'b0;
      key_ready_reg <= 1'b1;
    end else if (flush) begin
      state_reg     <= ST_IDLE;
      rk_valid_reg  <= 1'b0;
      key_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (key_valid) begin
            rk_reg        <= key;
            rk_idx_reg    <= '0;
            state_reg     <= ST_EMIT;
            rk_valid_reg  <= 1'b1;
            key_ready_reg <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (rk_ready) begin
            if (rk_idx_reg == LAST_IDX) begin
              state_reg     <= ST_IDLE;
              rk_valid_reg  <= 1'b0;
              key_ready_reg <= 1'b1;
            end else begin
              rk_reg     <= rk_next;
              rk_idx_reg <= rk_idx_reg + 4'd1;
            end
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          rk_valid_reg  <= 1'b0;
          key_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign key_ready = key_ready_reg;
  assign rk        = rk_reg;
  assign rk_idx    = rk_idx_reg;
  assign rk_valid  = rk_valid_reg;

`ifdef AES_KEY_SCHED_LAST_EN
  assign rk_last = rk_valid_reg & (rk_idx_reg == LAST_IDX);
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 and all-zero key vectors.
// Honours AES_KEY_SCHED_LAST_EN to exercise rk_last when the feature is built.
module tb_aes_key_sched;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  aes_block_t key = '0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  aes_block_t rk;
  logic [3:0] rk_idx;
  logic       rk_valid;
  logic       rk_ready = 1'b0;
`ifdef AES_KEY_SCHED_LAST_EN
  logic       rk_last;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK2 = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_sched #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .key       (key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk        (rk),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready)
`ifdef AES_KEY_SCHED_LAST_EN
    ,
    .rk_last   (rk_last)
`endif
  );

  always #5 clk = ~clk;

  // Hex string order (w0 MSB byte first) to block layout and back.
  function automatic aes_block_t to_block(input logic [127:0] h);
    aes_block_t b;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        b[i][j] = h[127 - 8 * (4 * i + j) -: 8];
    return b;
  endfunction

  function automatic logic [127:0] to_hex(input aes_block_t b);
    logic [127:0] h;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        h[127 - 8 * (4 * i + j) -: 8] = b[i][j];
    return h;
  endfunction

  // Offers a key for one cycle; returns at the sample point where rk_idx=0 is due.
  task automatic start_key(input logic [127:0] k);
    @(negedge clk);
    key       = to_block(k);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || rk_idx !== 4'd0 || to_hex(rk) !== 128'h0) begin
      errors++;
      $display("FAIL reset_in: valid=%b idx=%0d rk=%032h exp 0/0/0", rk_valid, rk_idx, to_hex(rk));
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: key_ready=%b rk_valid=%b exp 1/0", key_ready, rk_valid);
    end
    $display("reset: done");
  endtask

  task automatic test_fips;
    rk_ready = 1'b1;
    start_key(FIPS_KEY);
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || to_hex(rk) !== fips_rk[i]) begin
        errors++;
        $display("FAIL fips: valid=%b idx=%0d rk=%032h exp idx=%0d rk=%032h",
                 rk_valid, rk_idx, to_hex(rk), i, fips_rk[i]);
      end
`ifdef AES_KEY_SCHED_LAST_EN
      checks++;
      if (rk_last !== (i == 10)) begin
        errors++;
        $display("FAIL fips_last: idx=%0d rk_last=%b exp %b", i, rk_last, (i == 10));
      end
`endif
      $display("fips: idx=%0d rk=%032h", rk_idx, to_hex(rk));
      @(negedge clk);
    end
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || to_hex(rk) !== fips_rk[10]) begin
      errors++;
      $display("FAIL fips_end: valid=%b ready=%b rk=%032h exp 0/1/%032h",
               rk_valid, key_ready, to_hex(rk), fips_rk[10]);
    end
`ifdef AES_KEY_SCHED_LAST_EN
    checks++;
    if (rk_last !== 1'b0) begin
      errors++;
      $display("FAIL fips_last_idle: rk_last=%b exp 0", rk_last);
    end
`endif
    rk_ready = 1'b0;
  endtask

  task automatic test_stall;
    int  exp_idx;
    bit  done;
    logic r;
    exp_idx  = 0;
    done     = 0;
    rk_ready = 1'b0;
    start_key(FIPS_KEY);
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(exp_idx) || to_hex(rk) !== fips_rk[exp_idx]) begin
        errors++;
        $display("FAIL stall: cyc=%0d valid=%b idx=%0d rk=%032h exp idx=%0d rk=%032h",
                 cyc, rk_valid, rk_idx, to_hex(rk), exp_idx, fips_rk[exp_idx]);
      end
      r = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      rk_ready = r;
      $display("stall: cyc=%0d idx=%0d rk_ready=%b", cyc, rk_idx, r);
      @(negedge clk);
      if (r) begin
        if (exp_idx == 10) done = 1;
        else exp_idx++;
      end
    end
    checks++;
    if (!done || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: done=%0d rk_valid=%b exp 1/0", done, rk_valid);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_key_during_emit;
    rk_ready = 1'b1;
    start_key(FIPS_KEY);
    for (int i = 0; i <= 10; i++) begin
      if (i >= 3) begin
        key       = to_block(ZERO_KEY);
        key_valid = 1'b1;
      end
      checks++;
      if (key_ready !== 1'b0 || rk_idx !== 4'(i) || to_hex(rk) !== fips_rk[i]) begin
        errors++;
        $display("FAIL busy: key_ready=%b idx=%0d rk=%032h exp 0/%0d/%032h",
                 key_ready, rk_idx, to_hex(rk), i, fips_rk[i]);
      end
      $display("busy: idx=%0d key_valid=%b key_ready=%b", rk_idx, key_valid, key_ready);
      @(negedge clk);
    end
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: key_ready=%b rk_valid=%b exp 1/0", key_ready, rk_valid);
    end
    @(negedge clk);
    key_valid = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || to_hex(rk) !== ZERO_KEY) begin
      errors++;
      $display("FAIL busy_second0: valid=%b idx=%0d rk=%032h exp 1/0/%032h",
               rk_valid, rk_idx, to_hex(rk), ZERO_KEY);
    end
    @(negedge clk);
    checks++;
    if (rk_idx !== 4'd1 || to_hex(rk) !== ZERO_RK1) begin
      errors++;
      $display("FAIL busy_second1: idx=%0d rk=%032h exp 1/%032h", rk_idx, to_hex(rk), ZERO_RK1);
    end
    $display("busy: second key accepted after last handshake");
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    rk_ready = 1'b0;
  endtask

  task automatic test_flush;
    rk_ready = 1'b1;
    start_key(FIPS_KEY);
    repeat (4) @(negedge clk);
    checks++;
    if (rk_idx !== 4'd4 || to_hex(rk) !== fips_rk[4]) begin
      errors++;
      $display("FAIL flush_pre: idx=%0d rk=%032h exp 4/%032h", rk_idx, to_hex(rk), fips_rk[4]);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: rk_valid=%b key_ready=%b exp 0/1", rk_valid, key_ready);
    end
    $display("flush: aborted at idx 4");
    // Flush must also beat a key handshake offered in IDLE.
    key       = to_block(FIPS_KEY);
    key_valid = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    flush     = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_vs_key: rk_valid=%b key_ready=%b exp 0/1", rk_valid, key_ready);
    end
    start_key(ZERO_KEY);
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || to_hex(rk) !== ZERO_KEY) begin
      errors++;
      $display("FAIL flush_restart0: valid=%b idx=%0d rk=%032h exp 1/0/0", rk_valid, rk_idx, to_hex(rk));
    end
    @(negedge clk);
    checks++;
    if (rk_idx !== 4'd1 || to_hex(rk) !== ZERO_RK1) begin
      errors++;
      $display("FAIL flush_restart1: idx=%0d rk=%032h exp 1/%032h", rk_idx, to_hex(rk), ZERO_RK1);
    end
    $display("flush: restart idx=%0d rk=%032h", rk_idx, to_hex(rk));
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    rk_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    rk_ready = 1'b1;
    start_key(FIPS_KEY);
    repeat (6) @(negedge clk);
    checks++;
    if (rk_idx !== 4'd6 || to_hex(rk) !== fips_rk[6]) begin
      errors++;
      $display("FAIL rstmid_pre: idx=%0d rk=%032h exp 6/%032h", rk_idx, to_hex(rk), fips_rk[6]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (rk_valid !== 1'b0 || rk_idx !== 4'd0 || to_hex(rk) !== 128'h0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b idx=%0d rk=%032h ready=%b exp 0/0/0/1",
               rk_valid, rk_idx, to_hex(rk), key_ready);
    end
    $display("rstmid: async reset at idx 6");
    @(negedge clk);
    rst = 1'b1;
    start_key(ZERO_KEY);
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || to_hex(rk) !== ZERO_KEY) begin
      errors++;
      $display("FAIL rstmid_k0: valid=%b idx=%0d rk=%032h exp 1/0/0", rk_valid, rk_idx, to_hex(rk));
    end
    @(negedge clk);
    checks++;
    if (rk_idx !== 4'd1 || to_hex(rk) !== ZERO_RK1) begin
      errors++;
      $display("FAIL rstmid_k1: idx=%0d rk=%032h exp 1/%032h", rk_idx, to_hex(rk), ZERO_RK1);
    end
    @(negedge clk);
    checks++;
    if (rk_idx !== 4'd2 || to_hex(rk) !== ZERO_RK2) begin
      errors++;
      $display("FAIL rstmid_k2: idx=%0d rk=%032h exp 2/%032h", rk_idx, to_hex(rk), ZERO_RK2);
    end
    $display("rstmid: zero key idx=%0d rk=%032h", rk_idx, to_hex(rk));
    rk_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_stall();
    test_key_during_emit();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
